// File: rtl/skew_feeder_pkg.sv
// Package for the skew feeder: shared data-width default, FSM state encodings and a
// counter-width helper.
//
// Configuration macros used by this slice:
//   WIDTH_DATA          default element width per lane (8 when not supplied externally)
//   SKEW_STARVE_CNT_EN  enables the optional starve counter in skew_feeder

`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

package skew_feeder_pkg;

  typedef enum logic [1:0] {
    SKF_IDLE  = 2'd0,
    SKF_FEED  = 2'd1,
    SKF_FLUSH = 2'd2,
    SKF_DONE  = 2'd3
  } skf_state_e;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// skew_lane: DEPTH-stage {valid, data} shift chain for one lane of the skew feeder.
//
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   i_clear  synchronous soft reset (same effect as i_rst_n)
//   i_en     advance enable; the chain holds when low
//   i_vin    valid loaded into stage 0 on advance
//   i_din    data loaded into stage 0 on advance (replaced by zero when i_vin is low)
//   o_vout   valid of the last stage
//   o_dout   data of the last stage

module skew_lane
  import skew_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_vin,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_vout,
  output logic [WIDTH-1:0] o_dout
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_valid <= '0;
      for (int unsigned s = 0; s < DEPTH; s++) begin
        r_data[s] <= '0;
      end
    end else if (i_en) begin
      r_valid[0] <= i_vin;
      // Invalid stages always carry zero so the array sees clean padding.
      r_data[0]  <= i_vin ? i_din : '0;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign o_vout = r_valid[DEPTH-1];
  assign o_dout = r_data[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: input staging in front of the systolic MAC array. Accepts one LANES-wide
// vector per beat, delays lane i by i+1 advance cycles to form the diagonal wavefront,
// counts k_len beats per tile, flushes the skew with zeros and pulses tile_done.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_clear            synchronous soft reset; aborts a tile without tile_done
//   i_start, i_k_len   begin a tile of k_len beats (sampled in IDLE only)
//   i_stall            array freeze; nothing advances while high
//   i_in_valid/o_in_ready/i_in_data   upstream beat handshake; lane i = i_in_data[i*WIDTH +: WIDTH]
//   o_out_valid, o_out_data           skewed per-lane valid/data toward the array
//   o_busy             high whenever the FSM is not IDLE
//   o_tile_done        one-cycle pulse with the last lane output of a tile
//   o_starve_cnt       (SKEW_STARVE_CNT_EN only) saturating count of unstalled FEED cycles
//                      without input
//
// Optional feature macro: SKEW_STARVE_CNT_EN.

`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = `WIDTH_DATA,
  parameter int unsigned K_MAX = 256,
  parameter int unsigned KW    = $clog2(K_MAX + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_start,
  input  logic [KW-1:0]          i_k_len,
  input  logic                   i_stall,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [LANES*WIDTH-1:0] i_in_data,
  output logic [LANES-1:0]       o_out_valid,
  output logic [LANES*WIDTH-1:0] o_out_data,
  output logic                   o_busy,
  output logic                   o_tile_done
`ifdef SKEW_STARVE_CNT_EN
  ,
  output logic [31:0]            o_starve_cnt
`endif
);

  localparam int unsigned FW         = cnt_width(LANES);
  // Value of the flush counter on the final flush advance (LANES-1 advances in total).
  localparam int unsigned FLUSH_LAST = (LANES > 1) ? (LANES - 2) : 0;

  skf_state_e    r_state, w_state_nxt;
  logic [KW-1:0] r_k_len, w_k_len_nxt;
  logic [KW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [KW-1:0] w_beat_inc;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic          r_zero_done, w_zero_done_nxt;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_start_acc;

  // clear must win over an in-flight handshake, so ready is masked by it as well.
  assign w_in_ready  = (r_state == SKF_FEED) && !i_stall && !i_clear;
  assign w_accept    = i_in_valid && w_in_ready;
  assign w_beat_inc  = r_beat_cnt + KW'(1);
  assign w_start_acc = (r_state == SKF_IDLE) && i_start && !i_stall;

  always_comb begin
    w_state_nxt     = r_state;
    w_k_len_nxt     = r_k_len;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_zero_done_nxt = 1'b0;
    unique case (r_state)
      SKF_IDLE: begin
        if (w_start_acc) begin
          if (i_k_len == '0) begin
            // Empty tile: report completion without ever leaving IDLE.
            w_zero_done_nxt = 1'b1;
          end else begin
            w_state_nxt    = SKF_FEED;
            w_k_len_nxt    = i_k_len;
            w_beat_cnt_nxt = '0;
          end
        end
      end
      SKF_FEED: begin
        if (w_accept) begin
          w_beat_cnt_nxt = w_beat_inc;
          if (w_beat_inc == r_k_len) begin
            w_state_nxt     = (LANES == 1) ? SKF_DONE : SKF_FLUSH;
            w_flush_cnt_nxt = '0;
          end
        end
      end
      SKF_FLUSH: begin
        if (!i_stall) begin
          if (r_flush_cnt == FW'(FLUSH_LAST)) begin
            w_state_nxt = SKF_DONE;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt + FW'(1);
          end
        end
      end
      SKF_DONE: begin
        // Leaves unconditionally so tile_done is exactly one cycle even under stall.
        w_state_nxt = SKF_IDLE;
      end
      default: w_state_nxt = SKF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_state     <= SKF_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k_len     <= w_k_len_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_zero_done <= w_zero_done_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clear && w_start_acc) begin
      assert (i_k_len <= KW'(K_MAX))
        else $error("skew_feeder: k_len %0d exceeds K_MAX %0d", i_k_len, K_MAX);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    skew_lane #(
      .WIDTH (WIDTH),
      .DEPTH (g + 1)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_en    (!i_stall),
      .i_vin   (w_accept),
      .i_din   (i_in_data[g*WIDTH +: WIDTH]),
      .o_vout  (o_out_valid[g]),
      .o_dout  (o_out_data[g*WIDTH +: WIDTH])
    );
  end

`ifdef SKEW_STARVE_CNT_EN
  logic [31:0] r_starve_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_starve_cnt <= '0;
    end else if (w_start_acc) begin
      r_starve_cnt <= '0;
    end else if ((r_state == SKF_FEED) && !i_stall && !i_in_valid && (r_starve_cnt != '1)) begin
      r_starve_cnt <= r_starve_cnt + 32'd1;
    end
  end

  assign o_starve_cnt = r_starve_cnt;
`endif

  assign o_in_ready  = w_in_ready;
  assign o_busy      = (r_state != SKF_IDLE);
  assign o_tile_done = (r_state == SKF_DONE) || r_zero_done;

endmodule
